sw_debounce8: RTL and testbench
===============================

Name: sw_debounce8

Overview:
Eight-channel switch conditioner that sits directly upstream of the 8-to-3 priority encoder and drives its 8-bit data input.
- Synchronises raw board switches into the clock domain.
- Debounces each switch independently using a shared sample tick.
- Flags every change of the debounced vector, so the encoder and seven-segment path only ever see clean, glitch-free levels.

Parameters:
- WIDTH, 8, number of switch channels.
- TICK_DIV, 50000, clock cycles per debounce sample tick (≥1; 1 = sample every cycle).
- STABLE_TICKS, 20, consecutive differing samples needed before a channel output flips (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
- sw_raw  input  WIDTH  raw, asynchronous switch levels.
- sw_out  output  WIDTH  debounced levels; this is the encoder's data input.
- sw_rise  output  WIDTH  one-cycle pulse per channel when sw_out[i] goes 0→1.
- sw_fall  output  WIDTH  one-cycle pulse per channel when sw_out[i] goes 1→0.
- changed  output  1  one-cycle pulse when any bit of sw_out changed this cycle.

Behaviour:
- Reset (rst_n=0): the following all go to 0 immediately and hold while rst_n=0.
  - Synchroniser flops, prescaler, per-channel counters.
  - sw_out, sw_rise, sw_fall, changed.
- Synchroniser: two flops per channel; sync[i] = sw_raw[i] delayed 2 clk.
- Prescaler:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly one cycle when tick_cnt==TICK_DIV-1.
  - TICK_DIV=1 gives tick every cycle.
  - Width is clog2(TICK_DIV), minimum 1.
- Per-channel states: STABLE (cnt==0) and PENDING (cnt>0).
  - No tick: hold cnt and sw_out.
  - Tick, sync[i]==sw_out[i]: cnt←0, go to STABLE. This is the glitch rejection.
  - Tick, sync[i]!=sw_out[i], cnt<STABLE_TICKS-1: cnt←cnt+1, go to PENDING.
  - Tick, sync[i]!=sw_out[i], cnt==STABLE_TICKS-1: sw_out[i]←sync[i], cnt←0, go to STABLE.
  - Counter width is clog2(STABLE_TICKS); the counter never exceeds STABLE_TICKS-1 and never wraps.
- Edge outputs:
  - sw_rise, sw_fall and changed are registered and assert in the same cycle the new sw_out value first appears.
  - They deassert the next cycle.
  - changed = OR over channels of (sw_rise | sw_fall).
- Latency, for a clean input step that is held: sw_out follows no earlier than 2+(STABLE_TICKS-1)*TICK_DIV cycles and no later than 2+STABLE_TICKS*TICK_DIV cycles after the step.
- Rejection: a pulse or bounce train in which no run of STABLE_TICKS consecutive samples differs from sw_out never changes sw_out.
- Channels are fully independent.
  - Several channels may flip in the same cycle; each raises its own rise/fall bit and changed pulses once.
- Reset mid-PENDING: the count is discarded. After release, a held input needs the full latency again, measured from release.
- An input held constant at sw_out produces no output activity indefinitely.

Decomposition:
- Package sw_cond_pkg holds:
  - SW_WIDTH=8
  - default TICK_DIV and STABLE_TICKS
  - simulation overrides SIM_TICK_DIV=4, SIM_STABLE_TICKS=3
- One sub-module, debounce_chan: a single channel's synchroniser, counter and edge detect, with a tick input.
- The top holds the shared prescaler and generates WIDTH instances.

Test Plan (all tests use TICK_DIV=4, STABLE_TICKS=3):
- Reset: hold rst_n=0 with sw_raw=8'hFF → sw_out=8'h00, sw_rise=sw_fall=0, changed=0. Release and keep 8'hFF → sw_out=8'hFF within 2 to 14 cycles of release, with sw_rise=8'hFF and changed=1 for exactly one cycle.
- Clean step: sw_raw 8'h00→8'h10 and hold → sw_out=8'h10 between 10 and 14 cycles later; sw_rise=8'h10 for one cycle, with no other pulses.
- Bounce: on bit 7, toggle 0/1 every 3 cycles for 30 cycles, then settle at 1 → sw_out[7] stays 0 during the bounce, rises once after settling, and changed pulses exactly once.
- Glitch: on bit 0 (stable 0), a 1-cycle high pulse → sw_out, sw_rise, sw_fall and changed all stay 0 for 40 cycles.
- Simultaneous: sw_out=8'h0F, sw_raw→8'hF0 → sw_out goes 8'h0F→8'hF0 in a single cycle, with sw_rise=8'hF0, sw_fall=8'h0F and one changed pulse.
- Reset mid-pending: step bit 3 high, assert rst_n=0 eight cycles later for 2 cycles, then release → sw_out[3]=0 throughout reset, and it rises no earlier than 10 cycles after release.

Source files
------------

// File: rtl/sw_cond_pkg.sv
// Shared constants and types for the switch conditioner slice.
package sw_cond_pkg;

  localparam int SW_WIDTH         = 8;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 20;

  // Shorter timing used when simulating, so debounce runs finish in tens of cycles.
  localparam int SIM_TICK_DIV     = 4;
  localparam int SIM_STABLE_TICKS = 3;

  // A channel is STABLE when its counter is idle and PENDING while a change is being qualified.
  typedef enum logic {
    CHAN_STABLE  = 1'b0,
    CHAN_PENDING = 1'b1
  } chan_state_e;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: two-flop synchroniser, tick-driven stability counter,
// and registered rise/fall pulses that line up with the new debounced level.
import sw_cond_pkg::*;

module debounce_chan #(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw_raw,
  output logic sw_out,
  output logic sw_rise,
  output logic sw_fall,
  output logic flip_next
);

  localparam int            CW       = min1_clog2(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync_meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  chan_state_e   state_q, state_d;
  logic          out_q, out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Bring the asynchronous switch level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= sw_raw;
      sync_q      <= sync_meta_q;
    end
  end

  // On each tick, a sample matching the output discards any run; the last differing sample of a full run flips the output.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      if (sync_q == out_q) begin
        cnt_d   = '0;
        state_d = CHAN_STABLE;
      end else if ((state_q == CHAN_PENDING) && (cnt_q == CNT_LAST)) begin
        out_d   = sync_q;
        cnt_d   = '0;
        state_d = CHAN_STABLE;
        rise_d  = sync_q;
        fall_d  = ~sync_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = CHAN_PENDING;
      end
    end
  end

  // Register the counter, state, debounced level and edge pulses together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= CHAN_STABLE;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_out    = out_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign flip_next = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce8.sv
// Eight-channel switch conditioner feeding the priority encoder: shared
// sample prescaler, per-channel debounce, and an any-change strobe.
import sw_cond_pkg::*;

module sw_debounce8 #(
  parameter int WIDTH        = SW_WIDTH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  localparam int            TW        = min1_clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [WIDTH-1:0] flip_next;
  logic             changed_q, changed_d;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Prescaler wraps on the tick cycle; any channel flip next cycle raises the shared strobe.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    changed_d  = |flip_next;
  end

  // Register the prescaler and the change strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      changed_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      changed_q  <= changed_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .sw_raw   (sw_raw[i]),
      .sw_out   (sw_out[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i]),
      .flip_next(flip_next[i])
    );
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce8.sv
// Bench for sw_debounce8 with simulation timing: directed scenarios with
// literal expectations, then randomised stimulus against a window-based model.
module tb_sw_debounce8;
  import sw_cond_pkg::*;

  localparam int W  = SW_WIDTH;
  localparam int TD = SIM_TICK_DIV;
  localparam int ST = SIM_STABLE_TICKS;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_out, sw_rise, sw_fall;
  logic         changed;

  int vectors     = 0;
  int miscompares = 0;
  bit compareOn   = 1'b0;

  sw_debounce8 #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .sw_out(sw_out), .sw_rise(sw_rise), .sw_fall(sw_fall), .changed(changed)
  );

  always #5 clk = ~clk;

  // Reference model: a 2-deep delay line, a cycle position within the sample
  // period, and per channel the most recent ST samples. A channel flips when
  // it has ST samples since reset and every one of them differs from its output.
  logic [W-1:0] delayLine [2];
  bit           sampleHist [W][ST];
  int           samplesSeen [W];
  int           cycleInPeriod;
  logic [W-1:0] expOut, expRise, expFall;
  logic         expChanged;

  task automatic resetModel();
    delayLine[0] = '0;
    delayLine[1] = '0;
    for (int c = 0; c < W; c++) begin
      samplesSeen[c] = 0;
      for (int k = 0; k < ST; k++) sampleHist[c][k] = 1'b0;
    end
    cycleInPeriod = 0;
    expOut = '0; expRise = '0; expFall = '0; expChanged = 1'b0;
  endtask

  task automatic stepModel();
    logic [W-1:0] sampled;
    bit allDiffer;
    sampled = delayLine[1];
    expRise = '0;
    expFall = '0;
    if (cycleInPeriod == TD - 1) begin
      for (int c = 0; c < W; c++) begin
        for (int k = ST - 1; k > 0; k--) sampleHist[c][k] = sampleHist[c][k-1];
        sampleHist[c][0] = sampled[c];
        if (samplesSeen[c] < ST) samplesSeen[c]++;
        allDiffer = (samplesSeen[c] == ST);
        for (int k = 0; k < ST; k++) if (sampleHist[c][k] == expOut[c]) allDiffer = 1'b0;
        if (allDiffer) begin
          expOut[c] = sampled[c];
          if (sampled[c]) expRise[c] = 1'b1; else expFall[c] = 1'b1;
        end
      end
    end
    expChanged    = |(expRise | expFall);
    cycleInPeriod = (cycleInPeriod + 1) % TD;
    delayLine[1]  = delayLine[0];
    delayLine[0]  = sw_raw;
  endtask

  initial begin
    resetModel();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) resetModel();
      else        stepModel();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (compareOn) begin
        vectors++;
        if (sw_out !== expOut || sw_rise !== expRise || sw_fall !== expFall || changed !== expChanged) begin
          miscompares++;
          if (miscompares <= 20)
            $display("[TB] FAIL cycle_compare t=%0t out=%h/%h rise=%h/%h fall=%h/%h changed=%b/%b (got/exp)",
                     $time, sw_out, expOut, sw_rise, expRise, sw_fall, expFall, changed, expChanged);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [W-1:0] value);
    @(posedge clk); #2;
    sw_raw = value;
  endtask

  task automatic setReset(input logic level);
    @(posedge clk); #2;
    rst_n = level;
  endtask

  task automatic sampleCycle();
    @(posedge clk); #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h exp=%h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int value, input int lo, input int hi);
    vectors++;
    if (value < lo || value > hi) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0d exp=%0d..%0d", name, value, lo, hi);
    end
  endtask

  // Waits up to limit cycles for (sw_out & mask) == value; cycles is -1 on timeout.
  task automatic waitBits(input logic [W-1:0] mask, input logic [W-1:0] value, input int limit, output int cycles);
    int i;
    bit found;
    cycles = -1;
    found  = 1'b0;
    i      = 0;
    while (!found && i < limit) begin
      sampleCycle();
      i++;
      if ((sw_out & mask) == value) begin
        found  = 1'b1;
        cycles = i;
      end
    end
  endtask

  initial begin
    int  c;
    int  pulses;
    int  hold;
    logic ever7;
    logic [W-1:0] activity;
    logic [W-1:0] nextVal;

    // Reset with all switches on.
    #1 rst_n = 1'b0;
    sw_raw    = 8'hFF;
    compareOn = 1'b1;
    repeat (3) sampleCycle();
    checkOutput("reset_out", sw_out, 8'h00);
    checkOutput("reset_rise", sw_rise, 8'h00);
    checkOutput("reset_fall", sw_fall, 8'h00);
    checkOutput("reset_changed", {{(W-1){1'b0}}, changed}, 8'h00);
    setReset(1'b1);
    waitBits(8'hFF, 8'hFF, 30, c);
    checkRange("release_latency", c, 2, 14);
    checkOutput("release_rise", sw_rise, 8'hFF);
    checkOutput("release_changed", {{(W-1){1'b0}}, changed}, 8'h01);
    sampleCycle();
    checkOutput("release_rise_clear", sw_rise, 8'h00);
    checkOutput("release_changed_clear", {{(W-1){1'b0}}, changed}, 8'h00);

    // Clean step on bit 4.
    applyStimulus(8'h00);
    repeat (20) sampleCycle();
    checkOutput("step_setup", sw_out, 8'h00);
    applyStimulus(8'h10);
    waitBits(8'h10, 8'h10, 40, c);
    checkRange("step_latency", c, 10, 14);
    checkOutput("step_out", sw_out, 8'h10);
    checkOutput("step_rise", sw_rise, 8'h10);
    checkOutput("step_fall", sw_fall, 8'h00);
    sampleCycle();
    checkOutput("step_rise_clear", sw_rise, 8'h00);

    // Bounce on bit 7, then settle high.
    pulses = 0;
    ever7  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(((i / 3) % 2 == 0) ? 8'h90 : 8'h10);
      if (sw_out[7]) ever7 = 1'b1;
      pulses += int'(changed);
    end
    applyStimulus(8'h90);
    repeat (40) begin
      sampleCycle();
      pulses += int'(changed);
    end
    checkOutput("bounce_held_low", {{(W-1){1'b0}}, ever7}, 8'h00);
    checkOutput("bounce_changed_count", W'(pulses), 8'h01);
    checkOutput("bounce_final", sw_out, 8'h90);

    // One-cycle glitch on bit 0.
    applyStimulus(8'h91);
    applyStimulus(8'h90);
    activity = '0;
    repeat (40) begin
      sampleCycle();
      activity = activity | sw_rise | sw_fall | {{(W-1){1'b0}}, changed} | (sw_out ^ 8'h90);
    end
    checkOutput("glitch_activity", activity, 8'h00);

    // Simultaneous flip of all channels.
    applyStimulus(8'h0F);
    repeat (20) sampleCycle();
    checkOutput("simul_setup", sw_out, 8'h0F);
    applyStimulus(8'hF0);
    waitBits(8'hFF, 8'hF0, 40, c);
    checkRange("simul_latency", c, 10, 14);
    checkOutput("simul_rise", sw_rise, 8'hF0);
    checkOutput("simul_fall", sw_fall, 8'h0F);
    checkOutput("simul_changed", {{(W-1){1'b0}}, changed}, 8'h01);
    sampleCycle();
    checkOutput("simul_changed_clear", {{(W-1){1'b0}}, changed}, 8'h00);

    // Reset while bit 3 is still qualifying.
    applyStimulus(8'hF8);
    repeat (7) sampleCycle();
    checkOutput("pending_before_reset", sw_out, 8'hF0);
    setReset(1'b0);
    sampleCycle();
    checkOutput("pending_in_reset_a", sw_out, 8'h00);
    sampleCycle();
    checkOutput("pending_in_reset_b", sw_out, 8'h00);
    setReset(1'b1);
    waitBits(8'h08, 8'h08, 40, c);
    checkRange("post_reset_latency", c, 10, 40);

    // Randomised holds of varying length, with occasional short resets.
    for (int seg = 0; seg < 160; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        setReset(1'b0);
        repeat ($urandom_range(1, 3)) applyStimulus(W'($urandom));
        setReset(1'b1);
      end
      nextVal = sw_raw ^ W'($urandom & $urandom);
      hold    = $urandom_range(1, 24);
      applyStimulus(nextVal);
      repeat (hold) sampleCycle();
    end

    repeat (2) sampleCycle();
    compareOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
